mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter MULT_LATENCY, default 10, giving the cycles from MULT_GO high to a valid MULT_F_REG; legal range 1..15.
REQ-002 SHALL have port SYS_CLOCK  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port FSM_ARESET_N  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports REQ0_VALID / REQ1_VALID  in  1  requester n has an operand pair.
REQ-005 SHALL have ports REQ0_A, REQ0_B, REQ1_A, REQ1_B  in  3  unsigned operands per requester.
REQ-006 SHALL have ports REQ0_READY / REQ1_READY  out  1  operand pair accepted this cycle.
REQ-007 SHALL have ports RSP0_VALID / RSP1_VALID  out  1  product available for requester n.
REQ-008 SHALL have ports RSP0_F / RSP1_F  out  6  unsigned product.
REQ-009 SHALL have ports RSP0_READY / RSP1_READY  in  1  requester n takes the product.
REQ-010 SHALL have ports MULT_GO  out  1, and MULT_A, MULT_B  out  3, driving the shared 3x3 multiplier.
REQ-011 SHALL have port MULT_F_REG  in  6  multiplier result.
REQ-012 SHALL have port BUSY  out  1  high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, ISSUE, WAIT and RESPOND.
REQ-014 IDLE: if any REQn_VALID is high, SHALL pick a winner, assert only its REQn_READY for that cycle, capture its A/B and owner ID, and go to ISSUE.
REQ-015 SHALL assert REQn_READY only in IDLE; it is combinational from VALID and the arbitration result.
REQ-016 ISSUE: MULT_GO SHALL be high for exactly one cycle; SHALL load the wait counter with MULT_LATENCY and go to WAIT.
REQ-017 MULT_A/MULT_B SHALL carry the captured operands from ISSUE to the end of WAIT; otherwise they SHALL hold their last value.
REQ-018 WAIT: SHALL decrement the counter each cycle; on the cycle it reaches 0, SHALL register MULT_F_REG into the result register and go to RESPOND.
REQ-019 Latency: with acceptance at edge E0, RSPn_VALID SHALL first be high in cycle E0+2+MULT_LATENCY.
REQ-020 RESPOND: SHALL hold the owner's RSPn_VALID high and RSPn_F stable until RSPn_READY is high; on that edge SHALL return to IDLE.
REQ-021 SHALL keep the non-owner's RSP_VALID low; all RSPn_F outputs SHALL show the result register.
REQ-022 A request arriving while BUSY SHALL wait, with READY low, and SHALL not be lost if VALID stays high.
REQ-023 Simultaneous RSP return and new VALID: return to IDLE first; acceptance SHALL occur in the following cycle. No back-to-back bypass.
REQ-024 RSPn_READY outside RESPOND, or from the non-owner, SHALL be ignored.
REQ-025 Product width: 6 bits, no truncation (max 7*7=49).

Reset
REQ-026 Assertion SHALL immediately force: IDLE, all READY/VALID/GO low, MULT_A/MULT_B/RSPn_F = 0, counter 0, round-robin pointer set so REQ0 wins the next tie.
REQ-027 Reset during ISSUE/WAIT/RESPOND SHALL abort the operation with no response delivered.

Configuration
REQ-028 With MULT_ARB_RR_EN defined: round-robin; when both request, the requester not granted last SHALL win; the pointer updates on each grant.
REQ-029 Without MULT_ARB_RR_EN: fixed priority, REQ0 always wins ties; no pointer flop SHALL exist.

Structure
REQ-030 Package mult_arb_pkg SHALL hold the state enum typedef, the owner-ID typedef, and constants OPND_W=3 and PROD_W=6.
REQ-031 Sub-module mult_arb_pick SHALL hold the winner-selection logic (pointer + two VALIDs -> grant one-hot), with the macro applied there.

Verification
REQ-032 Single request: REQ0 A=5, B=6, MULT_LATENCY=10, model returns 30 -> RSP0_F=30 with RSP0_VALID first high at E0+12; RSP1_VALID stays 0.
REQ-033 Tie: both requesters VALID continuously with RR_EN defined -> grant order 0,1,0,1. Without the macro -> 0,0,0.
REQ-034 Backpressure: RSP1_READY held low 20 cycles -> RSP1_VALID and RSP1_F=49 (7x7) stay stable; REQ0 waits with READY low; grant follows the cycle after RSP1_READY.
REQ-035 Reset mid-WAIT: FSM_ARESET_N low 4 cycles after GO -> all outputs 0 at once, no RSP delivered; the next request is handled normally.
REQ-036 Boundary: MULT_LATENCY=1 with A=0, B=7 -> RSP_F=0 at E0+3; MULT_GO high in exactly one cycle per operation across 100 random requests.

Source files
------------

// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arb_pkg
// Description : Shared types and widths for the two-requester multiplier
//               arbiter: FSM state encoding, owner ID, operand/product widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

  localparam int OPND_W = 3;   // operand width
  localparam int PROD_W = 6;   // full product width, 7*7 = 49 fits
  localparam int CNT_W  = 4;   // wait counter, holds latencies 1..15

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_0 = 1'b0,
    OWNER_1 = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mult_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mult_arb_pick
// Description : Winner selection between two requesters. Produces a one-hot
//               grant from the two VALIDs. With MULT_ARB_RR_EN defined a
//               round-robin pointer breaks ties in favour of the requester
//               not granted last; otherwise REQ0 always wins a tie and no
//               pointer state exists.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arb_pick
  import mult_arb_pkg::*;
(
`ifdef MULT_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant_en,
`endif
  input  logic       valid0,
  input  logic       valid1,
  output logic [1:0] grant
);

`ifdef MULT_ARB_RR_EN
  owner_t ptr_q;
  owner_t ptr_d;

  // Tie goes to the requester the pointer favours; single requests pass through
  always_comb begin
    grant = {valid1, valid0};
    if (valid0 && valid1) begin
      grant = (ptr_q == OWNER_1) ? 2'b10 : 2'b01;
    end
  end

  // After each grant the other requester gets priority on the next tie
  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      ptr_d = grant[0] ? OWNER_1 : OWNER_0;
    end
  end

  // Pointer register; reset favours REQ0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= OWNER_0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: REQ0 wins whenever it is valid
  always_comb begin
    grant = {valid1 & ~valid0, valid0};
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Shares one external 3x3 multiplier between two requesters.
//               IDLE accepts one operand pair, ISSUE pulses MULT_GO, WAIT
//               counts MULT_LATENCY cycles then captures MULT_F_REG, RESPOND
//               holds the owner's response until it is taken.
//               Optional build macro: MULT_ARB_RR_EN (round-robin ties).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int MULT_LATENCY = 10
) (
  input  logic              SYS_CLOCK,
  input  logic              FSM_ARESET_N,
  input  logic              REQ0_VALID,
  input  logic              REQ1_VALID,
  input  logic [OPND_W-1:0] REQ0_A,
  input  logic [OPND_W-1:0] REQ0_B,
  input  logic [OPND_W-1:0] REQ1_A,
  input  logic [OPND_W-1:0] REQ1_B,
  output logic              REQ0_READY,
  output logic              REQ1_READY,
  output logic              RSP0_VALID,
  output logic              RSP1_VALID,
  output logic [PROD_W-1:0] RSP0_F,
  output logic [PROD_W-1:0] RSP1_F,
  input  logic              RSP0_READY,
  input  logic              RSP1_READY,
  output logic              MULT_GO,
  output logic [OPND_W-1:0] MULT_A,
  output logic [OPND_W-1:0] MULT_B,
  input  logic [PROD_W-1:0] MULT_F_REG,
  output logic              BUSY
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY);

  // Reject latencies the wait counter cannot represent
  if (MULT_LATENCY < 1 || MULT_LATENCY > 15) begin : g_bad_latency
    $error("mult_share_arbiter: MULT_LATENCY must be in 1..15");
  end

  state_t              state_q;
  state_t              state_d;
  owner_t              owner_q;
  owner_t              owner_d;
  logic [OPND_W-1:0]   a_q;
  logic [OPND_W-1:0]   a_d;
  logic [OPND_W-1:0]   b_q;
  logic [OPND_W-1:0]   b_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [PROD_W-1:0]   result_q;
  logic [PROD_W-1:0]   result_d;
  logic [1:0]          grant;
  logic                accept;
  logic                own_rsp_ready;

  assign accept        = (state_q == ST_IDLE) && (REQ0_VALID || REQ1_VALID);
  assign own_rsp_ready = (owner_q == OWNER_1) ? RSP1_READY : RSP0_READY;

  mult_arb_pick u_pick (
`ifdef MULT_ARB_RR_EN
    .clk      (SYS_CLOCK),
    .rst_n    (FSM_ARESET_N),
    .grant_en (accept),
`endif
    .valid0   (REQ0_VALID),
    .valid1   (REQ1_VALID),
    .grant    (grant)
  );

  // FSM state register
  always_ff @(posedge SYS_CLOCK or negedge FSM_ARESET_N) begin
    if (!FSM_ARESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one operation at a time, return to IDLE before a new accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept)          state_d = ST_ISSUE;
      ST_ISSUE:                        state_d = ST_WAIT;
      ST_WAIT:    if (cnt_q == '0)     state_d = ST_RESPOND;
      ST_RESPOND: if (own_rsp_ready)   state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshakes and the single-cycle multiplier start
  always_comb begin
    BUSY       = 1'b1;
    MULT_GO    = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    RSP0_VALID = 1'b0;
    RSP1_VALID = 1'b0;
    case (state_q)
      ST_IDLE: begin
        BUSY       = 1'b0;
        REQ0_READY = grant[0];
        REQ1_READY = grant[1];
      end
      ST_ISSUE: begin
        MULT_GO    = 1'b1;
      end
      ST_RESPOND: begin
        RSP0_VALID = (owner_q == OWNER_0);
        RSP1_VALID = (owner_q == OWNER_1);
      end
      default: begin
        BUSY       = 1'b1;
      end
    endcase
  end

  // Datapath: capture winner's operands, run the wait counter, latch product
  always_comb begin
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      owner_d = grant[1] ? OWNER_1 : OWNER_0;
      a_d     = grant[1] ? REQ1_A : REQ0_A;
      b_d     = grant[1] ? REQ1_B : REQ0_B;
    end
    if (state_q == ST_ISSUE) begin
      cnt_d = CNT_LOAD;
    end
    if (state_q == ST_WAIT) begin
      if (cnt_q == '0) begin
        result_d = MULT_F_REG;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Datapath registers; operands double as the held multiplier inputs
  always_ff @(posedge SYS_CLOCK or negedge FSM_ARESET_N) begin
    if (!FSM_ARESET_N) begin
      owner_q  <= OWNER_0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign MULT_A = a_q;
  assign MULT_B = b_q;
  assign RSP0_F = result_q;
  assign RSP1_F = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Self-checking bench for mult_share_arbiter. Two instances:
//               index 0 uses MULT_LATENCY=10, index 1 uses MULT_LATENCY=1.
//               A behavioural multiplier per instance returns A*B exactly
//               MULT_LATENCY cycles after GO and shows 63 before that.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       v0 [2], v1 [2], r0 [2], r1 [2];
  logic       rv0 [2], rv1 [2], rr0 [2], rr1 [2];
  logic       go [2], busy [2];
  logic [2:0] a0 [2], b0 [2], a1 [2], b1 [2], ma [2], mb [2];
  logic [5:0] f0 [2], f1 [2], mf [2], prod [2];
  int         mcnt [2];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit who;
    int a;
    int b;
    int f;
  } vec_t;
  vec_t vecs [6];

  int         n;
  int         seen;
  logic       got;
  logic       win;
  logic [3:0] tie_order;

  mult_share_arbiter #(.MULT_LATENCY(10)) u_dut (
    .SYS_CLOCK(clk), .FSM_ARESET_N(rst_n[0]),
    .REQ0_VALID(v0[0]), .REQ1_VALID(v1[0]),
    .REQ0_A(a0[0]), .REQ0_B(b0[0]), .REQ1_A(a1[0]), .REQ1_B(b1[0]),
    .REQ0_READY(r0[0]), .REQ1_READY(r1[0]),
    .RSP0_VALID(rv0[0]), .RSP1_VALID(rv1[0]),
    .RSP0_F(f0[0]), .RSP1_F(f1[0]),
    .RSP0_READY(rr0[0]), .RSP1_READY(rr1[0]),
    .MULT_GO(go[0]), .MULT_A(ma[0]), .MULT_B(mb[0]), .MULT_F_REG(mf[0]),
    .BUSY(busy[0])
  );

  mult_share_arbiter #(.MULT_LATENCY(1)) u_dut_l1 (
    .SYS_CLOCK(clk), .FSM_ARESET_N(rst_n[1]),
    .REQ0_VALID(v0[1]), .REQ1_VALID(v1[1]),
    .REQ0_A(a0[1]), .REQ0_B(b0[1]), .REQ1_A(a1[1]), .REQ1_B(b1[1]),
    .REQ0_READY(r0[1]), .REQ1_READY(r1[1]),
    .RSP0_VALID(rv0[1]), .RSP1_VALID(rv1[1]),
    .RSP0_F(f0[1]), .RSP1_F(f1[1]),
    .RSP0_READY(rr0[1]), .RSP1_READY(rr1[1]),
    .MULT_GO(go[1]), .MULT_A(ma[1]), .MULT_B(mb[1]), .MULT_F_REG(mf[1]),
    .BUSY(busy[1])
  );

  function automatic int lat(input bit i);
    return i ? 1 : 10;
  endfunction

  // Multiplier model: product valid MULT_LATENCY edges after the GO edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        mcnt[i] <= 0;
        mf[i]   <= 6'd63;
      end else if (go[i]) begin
        prod[i] <= {3'b000, ma[i]} * {3'b000, mb[i]};
        mcnt[i] <= lat(i[0]);
        mf[i]   <= 6'd63;
      end else if (mcnt[i] > 1) begin
        mcnt[i] <= mcnt[i] - 1;
      end else if (mcnt[i] == 1) begin
        mcnt[i] <= 0;
        mf[i]   <= prod[i];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full transaction on instance inst; called just after a falling edge
  task automatic run_op(input bit inst, input bit who, input int a, input int b, input int exp_f);
    int   k;
    int   gos;
    logic ok;
    if (!who) begin
      v0[inst] = 1'b1; a0[inst] = a[2:0]; b0[inst] = b[2:0];
    end else begin
      v1[inst] = 1'b1; a1[inst] = a[2:0]; b1[inst] = b[2:0];
    end
    #1;
    k  = 0;
    ok = who ? r1[inst] : r0[inst];
    while (!ok && k < 40) begin
      @(negedge clk);
      k++;
      ok = who ? r1[inst] : r0[inst];
    end
    check("accept", ok, 1);
    @(negedge clk);
    v0[inst] = 1'b0;
    v1[inst] = 1'b0;
    if (!ok) return;
    gos = go[inst] ? 1 : 0;
    k   = 0;
    ok  = 1'b0;
    while (!ok && k < 40) begin
      @(negedge clk);
      k++;
      if (go[inst]) gos++;
      ok = who ? rv1[inst] : rv0[inst];
    end
    check("latency", k, 2 + lat(inst));
    check("go_pulses", gos, 1);
    check("rsp_f", who ? f1[inst] : f0[inst], exp_f);
    check("other_valid_low", who ? rv0[inst] : rv1[inst], 0);
    if (who) rr1[inst] = 1'b1; else rr0[inst] = 1'b1;
    @(negedge clk);
    rr0[inst] = 1'b0;
    rr1[inst] = 1'b0;
    check("return_idle", busy[inst], 0);
    check("rsp_drop", who ? rv1[inst] : rv0[inst], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual still running, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; v0[i] = 1'b0; v1[i] = 1'b0; rr0[i] = 1'b0; rr1[i] = 1'b0;
      a0[i] = 3'd0; b0[i] = 3'd0; a1[i] = 3'd0; b1[i] = 3'd0;
    end
    vecs[0] = '{who: 1'b0, a: 5, b: 6, f: 30};
    vecs[1] = '{who: 1'b1, a: 7, b: 7, f: 49};
    vecs[2] = '{who: 1'b0, a: 0, b: 7, f: 0};
    vecs[3] = '{who: 1'b1, a: 3, b: 4, f: 12};
    vecs[4] = '{who: 1'b0, a: 7, b: 1, f: 7};
    vecs[5] = '{who: 1'b1, a: 6, b: 5, f: 30};
`ifdef MULT_ARB_RR_EN
    tie_order = 4'b1010;
`else
    tie_order = 4'b0000;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_go", go[0], 0);
    check("rst_mult_a", ma[0], 0);
    check("rst_mult_b", mb[0], 0);
    check("rst_rsp0_f", f0[0], 0);
    check("rst_rsp1_f", f1[0], 0);
    check("rst_rsp_valid", {rv1[0], rv0[0]}, 0);
    check("rst_req_ready", {r1[0], r0[0]}, 0);
    check("rst_busy_l1", busy[1], 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Single requests from a vector table
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].f);
    end

    // Both requesters valid continuously
    v0[0] = 1'b1; a0[0] = 3'd2; b0[0] = 3'd3;
    v1[0] = 1'b1; a1[0] = 3'd4; b1[0] = 3'd5;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      got = r0[0] | r1[0];
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        got = r0[0] | r1[0];
      end
      check("tie_accept", got, 1);
      check("tie_one_hot", r0[0] & r1[0], 0);
      win = r1[0];
      check("tie_grant", win, tie_order[k]);
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        got = win ? rv1[0] : rv0[0];
      end
      check("tie_rsp_f", win ? f1[0] : f0[0], win ? 20 : 6);
      if (win) rr1[0] = 1'b1; else rr0[0] = 1'b1;
      @(negedge clk);
      rr0[0] = 1'b0;
      rr1[0] = 1'b0;
    end
    v0[0] = 1'b0;
    v1[0] = 1'b0;
    @(negedge clk);

    // Backpressure on REQ1 while REQ0 waits; REQ0's stray RSP ready ignored
    v1[0] = 1'b1; a1[0] = 3'd7; b1[0] = 3'd7;
    #1;
    n = 0;
    got = r1[0];
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = r1[0];
    end
    check("bp_accept", got, 1);
    @(negedge clk);
    v1[0] = 1'b0;
    v0[0] = 1'b1; a0[0] = 3'd2; b0[0] = 3'd2;
    rr0[0] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = rv1[0];
    end
    check("bp_rsp_seen", got, 1);
    for (int k = 0; k < 20; k++) begin
      check("bp_valid_hold", rv1[0], 1);
      check("bp_f_hold", f1[0], 49);
      check("bp_req0_ready", r0[0], 0);
      check("bp_rsp0_valid", rv0[0], 0);
      @(negedge clk);
    end
    rr1[0] = 1'b1;
    rr0[0] = 1'b0;
    @(negedge clk);
    rr1[0] = 1'b0;
    check("bp_release", rv1[0], 0);
    check("bp_grant_next", r0[0], 1);
    @(negedge clk);
    v0[0] = 1'b0;
    check("bp_req0_taken", busy[0], 1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = rv0[0];
    end
    check("bp_req0_f", f0[0], 4);
    rr0[0] = 1'b1;
    @(negedge clk);
    rr0[0] = 1'b0;

    // Reset in the middle of WAIT
    v0[0] = 1'b1; a0[0] = 3'd5; b0[0] = 3'd5;
    #1;
    n = 0;
    got = r0[0];
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = r0[0];
    end
    check("mid_rst_accept", got, 1);
    @(negedge clk);
    v0[0] = 1'b0;
    check("mid_rst_go", go[0], 1);
    repeat (4) @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_go_low", go[0], 0);
    check("mid_rst_mult_a", ma[0], 0);
    check("mid_rst_mult_b", mb[0], 0);
    check("mid_rst_f", {f1[0], f0[0]}, 0);
    check("mid_rst_valid", {rv1[0], rv0[0]}, 0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rv0[0] || rv1[0] || busy[0]) seen = 1;
    end
    check("mid_rst_no_rsp", seen, 0);
    run_op(1'b0, 1'b0, 3, 3, 9);

    // Minimum latency instance: boundary operands then random traffic
    run_op(1'b1, 1'b0, 0, 7, 0);
    for (int k = 0; k < 100; k++) begin
      bit w;
      int ra;
      int rb;
      w  = 1'($urandom_range(0, 1));
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 7));
      run_op(1'b1, w, ra, rb, ra * rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
